list_walk_arbiter: RTL and testbench
====================================

# list_walk_arbiter

Shares one linked-list pointer-sequence walker among `NREQ` requesters. Each requester submits a head pointer. The block grants one request at a time in round-robin order and issues the head to the walker. It then forwards the walker's pointer stream tagged with the owner's id, and reports completion, list length and error to that owner. It sits between the client request ports and the walker's `start`/`out_ptr` interface, and holds off grants while the walker's next-pointer table is being initialised.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `n`, 16: number of list nodes; pointer 0 is the null pointer.
- `Width`, `$clog2(n)`: pointer width.
- `IW`, `$clog2(NREQ)`: requester id width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `init_vld`  in  1  walker table initialisation in progress; no grants while high.
- `req_vld`  in  NREQ  per-requester request valid.
- `req_ptr`  in  NREQ×Width  per-requester head pointer.
- `req_rdy`  out  NREQ  one-hot acceptance; a request is accepted in a cycle where `req_vld[i] & req_rdy[i]`.
- `wk_start`  out  Width  head pointer to walker.
- `wk_start_vld`  out  1  head valid to walker.
- `wk_start_rdy`  in  1  walker accepts head.
- `wk_ptr`  in  Width  walker pointer stream.
- `wk_ptr_vld`  in  1  walker pointer valid.
- `out_ptr`  out  Width  forwarded pointer.
- `out_ptr_vld`  out  1  forwarded pointer valid.
- `out_id`  out  IW  owner of `out_ptr`.
- `done`  out  NREQ  one-cycle completion pulse, one-hot.
- `done_len`  out  Width+1  number of pointers forwarded for the finished walk.
- `done_err`  out  1  walk aborted; qualified by `|done`.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WALK`.
- `IDLE`, when `~init_vld` and any `req_vld`:
  - Grant the first set `req_vld` scanning upward from `last_grant+1`, mod `NREQ`.
  - Latch the id and `req_ptr` in that cycle, assert `req_rdy[id]`, and set `last_grant <= id`.
  - Latched pointer ≠ 0: go to `ISSUE`.
  - Latched pointer = 0: no walker issue; next cycle `done[id]=1`, `done_len=0`, `done_err=0`; stay in `IDLE`.
- `ISSUE`:
  - `wk_start_vld=1` and `wk_start` = latched pointer, both held stable until `wk_start_rdy`.
  - On handshake, go to `WALK` and clear `len`/`seen`.
- `WALK`:
  - Each cycle with `wk_ptr_vld`: register `out_ptr<=wk_ptr`, `out_ptr_vld<=1`, `out_id<=id`; `len++`; `seen<=1`.
  - End when `seen` and `~wk_ptr_vld`: next cycle `done[id]=1`, `done_len=len`, `done_err=0`; go to `IDLE`.
- `len` is `Width+1` bits. If a forwarded pointer would make `len` exceed `n` (cyclic list):
  - That pointer is dropped.
  - `done[id]`, `done_err=1`, `done_len=n`; go to `IDLE`.
  - Any further `wk_ptr_vld` arriving in `IDLE` is discarded, never forwarded.
- `init_vld` rising in `ISSUE` or `WALK`: abort; next cycle `done[id]`, `done_err=1`, current `len`; go to `IDLE`.
- Round robin: `last_grant` updates only on acceptance. A requester holding `req_vld` is granted within `NREQ` walks.
- `wk_start_vld=0` outside `ISSUE`; `req_rdy=0` outside the `IDLE` grant cycle.

## Timing
- Reset values:
  - State `IDLE`, `last_grant=NREQ-1` (first grant goes to id 0).
  - Outputs: `req_rdy=0`, `wk_start_vld=0`, `wk_start=0`, `out_ptr_vld=0`, `out_ptr=0`, `out_id=0`, `done=0`, `done_len=0`, `done_err=0`.
- `req_rdy` is combinational from state, `init_vld` and `req_vld`. All other outputs are registered.
- Latency:
  - Accept → `wk_start_vld`: 1 cycle.
  - `wk_ptr` → `out_ptr`: 1 cycle.
  - Last `wk_ptr_vld` → `done`: 2 cycles.
- A new grant may occur in the same cycle `done` is high, since the FSM is already in `IDLE`.
- Reset mid-walk: all state clears immediately; no `done` is issued.

## Test plan
The walker is loaded with: 1→5→3→10, 2→4, 6, 7→15→8, 9→14→11→13→12.
- Req0 ptr 7 alone → `out_ptr` 7,15,8 with `out_id=0`; `done[0]`, `done_len=3`, `done_err=0`.
- Req0=1, req1=9, req2=2, all held from reset → grant order 0,1,2. Streams are 1,5,3,10 / 9,14,11,13,12 / 2,4, with `done_len` 4, 5, 2 and no interleaving of ids.
- Req3 ptr 0 → `req_rdy[3]` for one cycle, then `done[3]`, `done_len=0`, no `wk_start_vld`.
- `req_vld` high while `init_vld=1` → no `req_rdy`; first grant in the cycle after `init_vld` falls.
- Walker table modified to 6→6 (cycle) → exactly 16 pointers forwarded, then `done_err=1`, `done_len=16`.
- `rst` asserted during the walk from 9 → all outputs 0 asynchronously; after release, req1 ptr 6 → `done[1]`, `done_len=1`.

Source files
------------

// File: rtl/list_walk_arbiter.sv
// rtl/list_walk_arbiter.sv - round-robin arbiter sharing one linked-list walker among requesters
module list_walk_arbiter #(
    parameter int NREQ  = 4,
    parameter int n     = 16,
    parameter int Width = $clog2(n),
    parameter int IW    = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_vld,
    input  logic [NREQ-1:0]            req_vld,
    input  logic [NREQ-1:0][Width-1:0] req_ptr,
    output logic [NREQ-1:0]            req_rdy,
    output logic [Width-1:0]           wk_start,
    output logic                       wk_start_vld,
    input  logic                       wk_start_rdy,
    input  logic [Width-1:0]           wk_ptr,
    input  logic                       wk_ptr_vld,
    output logic [Width-1:0]           out_ptr,
    output logic                       out_ptr_vld,
    output logic [IW-1:0]              out_id,
    output logic [NREQ-1:0]            done,
    output logic [Width:0]             done_len,
    output logic                       done_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WALK
    } state_t;

    // A list longer than the node count can only mean the table loops back on itself.
    localparam logic [Width:0] LEN_MAX = (Width+1)'(n);

    state_t           state;
    state_t           state_n;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    id_q;
    logic [IW-1:0]    gnt_id;
    logic [IW-1:0]    idx;
    logic             gnt_any;
    logic             grant;
    logic [Width-1:0] gnt_ptr;
    logic [NREQ-1:0]  gnt_onehot;
    logic [NREQ-1:0]  id_onehot;
    logic [Width:0]   len;
    logic             seen;
    logic             overflow;

    // Round-robin scan starting just after the most recently accepted requester.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NREQ);
            if (!gnt_any && req_vld[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign grant    = (state == IDLE) && !init_vld && gnt_any;
    assign gnt_ptr  = req_ptr[gnt_id];
    assign overflow = wk_ptr_vld && (len == LEN_MAX);

    // One-hot decodes of the candidate grant and of the current owner.
    always_comb begin
        gnt_onehot         = '0;
        gnt_onehot[gnt_id] = 1'b1;
        id_onehot          = '0;
        id_onehot[id_q]    = 1'b1;
    end

    // Acceptance is combinational so a requester sees it in the grant cycle; held low in reset.
    always_comb begin
        req_rdy = '0;
        if (grant && !rst) begin
            req_rdy = gnt_onehot;
        end
    end

    // Next-state selection; a null head never leaves IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant && (gnt_ptr != '0)) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (init_vld) begin
                    state_n = IDLE;
                end else if (wk_start_rdy) begin
                    state_n = WALK;
                end
            end
            WALK: begin
                if (init_vld || overflow || (seen && !wk_ptr_vld)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Grant bookkeeping, walker handoff, stream forwarding and completion reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= IW'(NREQ-1);
            id_q         <= '0;
            len          <= '0;
            seen         <= 1'b0;
            wk_start     <= '0;
            wk_start_vld <= 1'b0;
            out_ptr      <= '0;
            out_ptr_vld  <= 1'b0;
            out_id       <= '0;
            done         <= '0;
            done_len     <= '0;
            done_err     <= 1'b0;
        end else begin
            wk_start_vld <= (state_n == ISSUE);
            out_ptr_vld  <= 1'b0;
            done         <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        id_q       <= gnt_id;
                        last_grant <= gnt_id;
                        len        <= '0;
                        seen       <= 1'b0;
                        if (gnt_ptr != '0) begin
                            wk_start <= gnt_ptr;
                        end else begin
                            done     <= gnt_onehot;
                            done_len <= '0;
                            done_err <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (init_vld) begin
                        done     <= id_onehot;
                        done_len <= len;
                        done_err <= 1'b1;
                    end else if (wk_start_rdy) begin
                        len  <= '0;
                        seen <= 1'b0;
                    end
                end
                WALK: begin
                    if (init_vld) begin
                        done     <= id_onehot;
                        done_len <= len;
                        done_err <= 1'b1;
                    end else if (overflow) begin
                        done     <= id_onehot;
                        done_len <= LEN_MAX;
                        done_err <= 1'b1;
                    end else if (wk_ptr_vld) begin
                        out_ptr     <= wk_ptr;
                        out_ptr_vld <= 1'b1;
                        out_id      <= id_q;
                        len         <= len + 1'b1;
                        seen        <= 1'b1;
                    end else if (seen) begin
                        done     <= id_onehot;
                        done_len <= len;
                        done_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_list_walk_arbiter.sv
// tb/tb_list_walk_arbiter.sv - self-checking bench for list_walk_arbiter
module tb_list_walk_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 16;
    localparam int W    = 4;
    localparam int IW   = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   init_vld;
    logic [NREQ-1:0]        req_vld;
    logic [NREQ-1:0][W-1:0] req_ptr;
    logic [NREQ-1:0]        req_rdy;
    logic [W-1:0]           wk_start;
    logic                   wk_start_vld;
    logic                   wk_start_rdy;
    logic [W-1:0]           wk_ptr;
    logic                   wk_ptr_vld;
    logic [W-1:0]           out_ptr;
    logic                   out_ptr_vld;
    logic [IW-1:0]          out_id;
    logic [NREQ-1:0]        done;
    logic [W:0]             done_len;
    logic                   done_err;

    list_walk_arbiter #(.NREQ(NREQ), .n(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .init_vld     (init_vld),
        .req_vld      (req_vld),
        .req_ptr      (req_ptr),
        .req_rdy      (req_rdy),
        .wk_start     (wk_start),
        .wk_start_vld (wk_start_vld),
        .wk_start_rdy (wk_start_rdy),
        .wk_ptr       (wk_ptr),
        .wk_ptr_vld   (wk_ptr_vld),
        .out_ptr      (out_ptr),
        .out_ptr_vld  (out_ptr_vld),
        .out_id       (out_id),
        .done         (done),
        .done_len     (done_len),
        .done_err     (done_err)
    );

    always #5 clk = ~clk;

    typedef struct { int ptr; int id; } pe_t;
    typedef struct { int id; int len; int err; } de_t;

    pe_t exp_ptr_q[$];
    de_t exp_done_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_off   = 1'b0;

    // walker and requester models
    logic [3:0]      tbl [16];
    bit              wk_pend, wk_busy;
    logic [3:0]      wk_head, wk_cur;
    int              wk_emitted, wk_cap;
    int              rdy_lat, rdy_wait;
    bit              init_want;
    bit [NREQ-1:0]   req_arm, req_drop;
    logic [3:0]      arm_ptr [NREQ];
    int              mdl_last;

    // observation logs
    int cyc, last_wk_cyc, done_cyc, fall_cyc;
    int acc_cyc [NREQ];
    int wsv_cnt, wsv_first, wsv_first_cyc, wsv_changes, rdy_hi_cnt, out_cnt;
    int grant_log[$];
    int done_len_log[$];
    int out_log[$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // round-robin choice among a request mask, from the last accepted id
    function automatic int rr_pick(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            logic [1:0] j;
            j = 2'((mdl_last + k) % NREQ);
            if (mask[j]) begin
                mdl_last = int'(j);
                return int'(j);
            end
        end
        return -1;
    endfunction

    // expected stream and completion for one walk; abort_after >= 0 cuts the walk after that many
    function automatic void expect_walk(input int id, input logic [3:0] head, input int abort_after);
        logic [3:0] cur;
        int len;
        int err;
        cur = head;
        len = 0;
        err = 0;
        while (cur != 4'd0) begin
            if ((abort_after >= 0 && len == abort_after) || len == N) begin
                err = 1;
                break;
            end
            exp_ptr_q.push_back('{int'(cur), id});
            len++;
            cur = tbl[cur];
        end
        exp_done_q.push_back('{id, len, err});
    endfunction

    task automatic tick();
        @(negedge clk);
        if (wk_pend) begin
            wk_busy    = 1'b1;
            wk_cur     = wk_head;
            wk_emitted = 0;
            wk_pend    = 1'b0;
        end
        if (wk_busy) begin
            wk_ptr_vld = 1'b1;
            wk_ptr     = wk_cur;
            wk_emitted++;
            wk_cur = tbl[wk_cur];
            if (wk_cur == 4'd0 || wk_emitted >= wk_cap) wk_busy = 1'b0;
        end else begin
            wk_ptr_vld = 1'b0;
            wk_ptr     = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_drop[i]) begin
                req_vld[i]  = 1'b0;
                req_drop[i] = 1'b0;
            end
            if (req_arm[i]) begin
                req_vld[i] = 1'b1;
                req_ptr[i] = arm_ptr[i];
                req_arm[i] = 1'b0;
            end
        end
        init_vld     = init_want;
        wk_start_rdy = (rdy_wait >= rdy_lat);
        #4;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_vld[i] && req_rdy[i]) begin
                req_drop[i] = 1'b1;
                grant_log.push_back(i);
                acc_cyc[i] = cyc;
            end
        end
        if (req_rdy != '0) rdy_hi_cnt++;
        if (wk_start_vld) begin
            wsv_cnt++;
            if (wsv_cnt == 1) begin
                wsv_first     = int'(wk_start);
                wsv_first_cyc = cyc;
            end else if (int'(wk_start) != wsv_first) begin
                wsv_changes++;
            end
        end
        if (wk_start_vld && wk_start_rdy) begin
            wk_pend  = 1'b1;
            wk_head  = wk_start;
            rdy_wait = 0;
        end else if (wk_start_vld) begin
            rdy_wait++;
        end
        if (wk_ptr_vld) last_wk_cyc = cyc;
        if (out_ptr_vld) begin
            out_cnt++;
            out_log.push_back(int'(out_ptr));
        end
        if (done != '0) begin
            done_cyc = cyc;
            done_len_log.push_back(int'(done_len));
        end
    endtask

    task automatic wait_quiet(input string tag, input int max_cyc);
        int k;
        k = 0;
        while ((exp_ptr_q.size() != 0 || exp_done_q.size() != 0) && k < max_cyc) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, exp_ptr_q.size() + exp_done_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_rdy"}, int'(req_rdy), 0);
        check({tag, "_wk_start_vld"}, int'(wk_start_vld), 0);
        check({tag, "_wk_start"}, int'(wk_start), 0);
        check({tag, "_out_ptr_vld"}, int'(out_ptr_vld), 0);
        check({tag, "_out_ptr"}, int'(out_ptr), 0);
        check({tag, "_out_id"}, int'(out_id), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_done_len"}, int'(done_len), 0);
        check({tag, "_done_err"}, int'(done_err), 0);
    endtask

    // scoreboard: every forwarded pointer and every completion against the model queues
    initial begin
        pe_t pe;
        de_t de;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && !sb_off) begin
                if (out_ptr_vld) begin
                    if (exp_ptr_q.size() == 0) begin
                        check("out_stray", int'(out_ptr_vld), 0);
                    end else begin
                        pe = exp_ptr_q.pop_front();
                        check("out_ptr", int'(out_ptr), pe.ptr);
                        check("out_id", int'(out_id), pe.id);
                    end
                end
                if (done != '0) begin
                    if (exp_done_q.size() == 0) begin
                        check("done_stray", int'(done), 0);
                    end else begin
                        de = exp_done_q.pop_front();
                        check("done_vec", int'(done), 1 << de.id);
                        check("done_len", int'(done_len), de.len);
                        check("done_err", int'(done_err), de.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] mask;
        logic [3:0]      heads [NREQ];
        int              id;
        int              k;

        for (int i = 0; i < 16; i++) tbl[i] = 4'd0;
        tbl[1] = 4'd5;   tbl[5] = 4'd3;   tbl[3] = 4'd10;
        tbl[2] = 4'd4;
        tbl[7] = 4'd15;  tbl[15] = 4'd8;
        tbl[9] = 4'd14;  tbl[14] = 4'd11; tbl[11] = 4'd13; tbl[13] = 4'd12;

        wk_pend = 1'b0; wk_busy = 1'b0; wk_head = '0; wk_cur = '0;
        wk_emitted = 0; wk_cap = 32; rdy_lat = 0; rdy_wait = 0;
        init_want = 1'b0; req_arm = '0; req_drop = '0;
        for (int i = 0; i < NREQ; i++) begin
            arm_ptr[i] = '0;
            acc_cyc[i] = -1;
        end
        cyc = 0; last_wk_cyc = -1; done_cyc = -1; fall_cyc = -1;
        wsv_cnt = 0; wsv_first = -1; wsv_first_cyc = -1; wsv_changes = 0;
        rdy_hi_cnt = 0; out_cnt = 0;
        mdl_last = NREQ - 1;

        init_vld = 1'b0; wk_start_rdy = 1'b1; wk_ptr = '0; wk_ptr_vld = 1'b0;
        heads[0] = 4'd1; heads[1] = 4'd9; heads[2] = 4'd2; heads[3] = 4'd0;
        req_vld = 4'b0111;
        for (int i = 0; i < NREQ; i++) req_ptr[i] = heads[i];
        rst = 1'b1;

        // reset state with requests already pending
        repeat (2) tick();
        check_all_zero("reset");

        // three held requests: granted 0,1,2 without interleaving
        mask = 4'b0111;
        for (int g = 0; g < 3; g++) begin
            id = rr_pick(mask);
            expect_walk(id, heads[id], -1);
            mask[id] = 1'b0;
        end
        grant_log.delete();
        done_len_log.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        wait_quiet("rr3", 200);
        check("rr3_ngrant", grant_log.size(), 3);
        check("rr3_grant0", grant_log[0], 0);
        check("rr3_grant1", grant_log[1], 1);
        check("rr3_grant2", grant_log[2], 2);
        check("rr3_len0", done_len_log[0], 4);
        check("rr3_len1", done_len_log[1], 5);
        check("rr3_len2", done_len_log[2], 2);
        check("rr3_start_lat", wsv_first_cyc - acc_cyc[0], 1);

        // single walk from 7 with a slow walker start handshake
        wsv_cnt = 0; wsv_changes = 0; out_log.delete(); done_len_log.delete();
        rdy_lat = 2;
        id = rr_pick(4'b0001);
        expect_walk(id, 4'd7, -1);
        arm_ptr[0] = 4'd7; req_arm[0] = 1'b1;
        wait_quiet("w7", 100);
        rdy_lat = 0;
        check("w7_nout", out_log.size(), 3);
        check("w7_out0", out_log[0], 7);
        check("w7_out1", out_log[1], 15);
        check("w7_out2", out_log[2], 8);
        check("w7_len", done_len_log[0], 3);
        check("w7_done_lat", done_cyc - last_wk_cyc, 2);
        check("w7_start_cycles", wsv_cnt, 3);
        check("w7_start_stable", wsv_changes, 0);
        check("w7_start_ptr", wsv_first, 7);

        // null head: one-cycle accept, done the next cycle, walker untouched
        wsv_cnt = 0; rdy_hi_cnt = 0; done_len_log.delete(); acc_cyc[3] = -1;
        id = rr_pick(4'b1000);
        expect_walk(id, 4'd0, -1);
        arm_ptr[3] = 4'd0; req_arm[3] = 1'b1;
        wait_quiet("null", 50);
        check("null_rdy_cycles", rdy_hi_cnt, 1);
        check("null_done_lat", done_cyc - acc_cyc[3], 1);
        check("null_no_start", wsv_cnt, 0);
        check("null_len", done_len_log[0], 0);

        // grants held off during table initialisation
        init_want = 1'b1;
        tick();
        rdy_hi_cnt = 0; acc_cyc[1] = -1;
        id = rr_pick(4'b0010);
        expect_walk(id, 4'd6, -1);
        arm_ptr[1] = 4'd6; req_arm[1] = 1'b1;
        repeat (5) tick();
        check("init_hold_rdy", rdy_hi_cnt, 0);
        init_want = 1'b0;
        tick();
        fall_cyc = cyc;
        check("init_first_grant", acc_cyc[1], fall_cyc);
        wait_quiet("init", 50);

        // initialisation starting mid-walk aborts it
        out_cnt = 0; done_len_log.delete();
        id = rr_pick(4'b0100);
        expect_walk(id, 4'd9, 2);
        arm_ptr[2] = 4'd9; req_arm[2] = 1'b1;
        k = 0;
        while (!(wk_busy && wk_emitted == 2) && k < 50) begin
            tick();
            k++;
        end
        init_want = 1'b1;
        repeat (5) tick();
        init_want = 1'b0;
        wait_quiet("abort", 50);
        check("abort_nout", out_cnt, 2);
        check("abort_len", done_len_log[0], 2);

        // cyclic list 6->6: capped at the node count, extra pointers discarded
        tbl[6] = 4'd6; wk_cap = 20; out_cnt = 0; done_len_log.delete();
        id = rr_pick(4'b1000);
        expect_walk(id, 4'd6, -1);
        arm_ptr[3] = 4'd6; req_arm[3] = 1'b1;
        wait_quiet("cyc", 100);
        repeat (4) tick();
        check("cyc_nout", out_cnt, 16);
        check("cyc_len", done_len_log[0], 16);
        tbl[6] = 4'd0; wk_cap = 32;

        // reset in the middle of the walk from 9
        sb_off = 1'b1;
        arm_ptr[0] = 4'd9; req_arm[0] = 1'b1;
        k = 0;
        while (!(wk_busy && wk_emitted == 3) && k < 50) begin
            tick();
            k++;
        end
        @(posedge clk);
        #1;
        check("pre_rst_out_vld", int'(out_ptr_vld), 1);
        check("pre_rst_out_ptr", int'(out_ptr), 11);
        #1 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        wk_busy = 1'b0; wk_pend = 1'b0; req_vld = '0; req_drop = '0; rdy_wait = 0;
        wk_ptr_vld = 1'b0; wk_ptr = '0;
        mdl_last = NREQ - 1;
        exp_ptr_q.delete(); exp_done_q.delete();
        repeat (2) tick();
        check("midrst_done_held", int'(done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb_off = 1'b0;
        grant_log.delete(); done_len_log.delete();
        id = rr_pick(4'b0010);
        expect_walk(id, 4'd6, -1);
        arm_ptr[1] = 4'd6; req_arm[1] = 1'b1;
        wait_quiet("postrst", 50);
        check("postrst_ndone", done_len_log.size(), 1);
        check("postrst_len", done_len_log[0], 1);
        check("postrst_grant", grant_log[0], 1);

        check("sb_drain", exp_ptr_q.size() + exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
